// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: jump opcodes, the NOP word and fetch FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package fetch_unit_pkg;

   // Opcode field inst[31:27] values for the control-transfer instructions.
   // They are resolved downstream; fetch only ever sees the resulting redirect.
   localparam logic [4:0] OP_JR   = 5'b01101;
   localparam logic [4:0] OP_JPC  = 5'b01110;
   localparam logic [4:0] OP_CALL = 5'b10000;

   // All-zeros instruction presented whenever valid is low.
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // EMPTY:    nothing in flight and the skid is empty.
   // INFLIGHT: one program-memory read is outstanding (data arrives this cycle).
   // HELD:     the returned instruction is parked in the skid buffer.
   typedef enum logic [1:0] {
      FETCH_EMPTY    = 2'b00,
      FETCH_INFLIGHT = 2'b01,
      FETCH_HELD     = 2'b10
   } fetch_state_t;

   // Decode helper for downstream stages that need to spot a redirecting opcode.
   function automatic logic is_jump_op(input logic [4:0] op);
      return (op == OP_JR) || (op == OP_JPC) || (op == OP_CALL);
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction returned while decode is stalled.
// Latency: captured data is visible on the edge after capture.
// Backpressure: none of its own; clear wins over capture.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   capture         load in_addr/in_inst and mark the entry valid
//   clear           drop the entry (advance or redirect)
//   in_addr/in_inst address and instruction returned by program memory
//   skid_addr/skid_inst/skid_valid  stored entry
module fetch_skid
   import fetch_unit_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              clear,
   input  logic [DWIDTH-1:0] in_addr,
   input  logic [DWIDTH-1:0] in_inst,
   output logic [DWIDTH-1:0] skid_addr,
   output logic [DWIDTH-1:0] skid_inst,
   output logic              skid_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_addr  <= '0;
         skid_inst  <= DWIDTH'(NOP_WORD);
         skid_valid <= 1'b0;
      end else if (clear) begin
         // Data is left in place; only the valid flag matters once cleared.
         skid_valid <= 1'b0;
      end else if (capture) begin
         skid_addr  <= in_addr;
         skid_inst  <= in_inst;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, one outstanding pmem read, skid for stalls.
// Latency: two rising edges from an issued request to inst/valid at decode.
// Backpressure: stall freezes outputs and pc; an in-flight read is parked in the skid.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   stall                    decode cannot accept a new instruction
//   redirect/redirect_target taken jump resolved downstream and its destination
//   pmem_en/pmem_addr        program-memory read request (combinational)
//   pmem_data                read data, valid one cycle after an enabled request
//   addr/inst/valid          instruction presented to decode (registered)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 DWIDTH   = 32,
   parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [DWIDTH-1:0] redirect_target,
   output logic              pmem_en,
   output logic [DWIDTH-1:0] pmem_addr,
   input  logic [DWIDTH-1:0] pmem_data,
   output logic [DWIDTH-1:0] addr,
   output logic [DWIDTH-1:0] inst,
   output logic              valid
);

   localparam logic [DWIDTH-1:0] NOP = DWIDTH'(NOP_WORD);
   localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);

   fetch_state_t      state;
   logic [DWIDTH-1:0] pc;        // next sequential address to request
   logic [DWIDTH-1:0] req_addr;  // address of the read currently in flight

   logic              skid_capture;
   logic              skid_clear;
   logic [DWIDTH-1:0] skid_addr;
   logic [DWIDTH-1:0] skid_inst;
   logic              skid_valid;

   // A request is issued on every edge that either advances or redirects, so
   // the memory enable mirrors exactly those two conditions.
   always_comb begin
      pmem_en   = ~stall | redirect;
      pmem_addr = redirect ? redirect_target : pc;
   end

   // Park the returning instruction only when decode is blocked and the read
   // data is actually on pmem_data this cycle (i.e. a read is in flight).
   always_comb begin
      skid_capture = stall & ~redirect & (state == FETCH_INFLIGHT);
      skid_clear   = redirect | ~stall;
   end

   fetch_skid #(
      .DWIDTH(DWIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .capture    (skid_capture),
      .clear      (skid_clear),
      .in_addr    (req_addr),
      .in_inst    (pmem_data),
      .skid_addr  (skid_addr),
      .skid_inst  (skid_inst),
      .skid_valid (skid_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH_EMPTY;
         pc       <= RESET_PC;
         req_addr <= '0;
         addr     <= '0;
         inst     <= NOP;
         valid    <= 1'b0;
      end else if (redirect) begin
         // Whatever is in flight, parked or presented belongs to the wrong
         // path; restart the stream at the target. addr is left as-is since
         // valid is low.
         state    <= FETCH_INFLIGHT;
         req_addr <= redirect_target;
         pc       <= redirect_target + ONE;
         valid    <= 1'b0;
         inst     <= NOP;
      end else if (stall) begin
         // Outputs and pc hold. The read that returns now must not be lost,
         // so it moves into the skid (captured by u_skid) and we go HELD.
         if (state == FETCH_INFLIGHT) begin
            state <= FETCH_HELD;
         end
      end else begin
         case (state)
            FETCH_HELD: begin
               addr  <= skid_addr;
               inst  <= skid_inst;
               valid <= skid_valid;
            end
            FETCH_INFLIGHT: begin
               addr  <= req_addr;
               inst  <= pmem_data;
               valid <= 1'b1;
            end
            default: begin
               valid <= 1'b0;
               inst  <= NOP;
            end
         endcase
         // Every advance issues the next sequential read; pc wraps naturally.
         state    <= FETCH_INFLIGHT;
         req_addr <= pc;
         pc       <= pc + ONE;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stall/redirect traffic.
// Latency: n/a.
// Backpressure: the bench drives stall and redirect; memory answers one cycle after pmem_en.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        pmem_en;
   logic [31:0] pmem_addr;
   logic [31:0] pmem_data = '0;
   logic [31:0] addr;
   logic [31:0] inst;
   logic        valid;

   int          n_checks   = 0;
   int          n_fail     = 0;
   int          n_consumed = 0;

   // Reference model state: the next address the stream must request, and the
   // next address decode must receive.
   logic [31:0] exp_req = RST_PC;
   logic [31:0] exp_out = RST_PC;

   fetch_unit #(
      .DWIDTH   (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .pmem_en         (pmem_en),
      .pmem_addr       (pmem_addr),
      .pmem_data       (pmem_data),
      .addr            (addr),
      .inst            (inst),
      .valid           (valid)
   );

   always #5 clk = ~clk;

   // Program memory: word at address a holds 0x1000 + a. Data is only
   // meaningful the cycle after an enabled read; otherwise it is junk.
   always @(posedge clk) begin
      if (pmem_en) pmem_data <= 32'h1000 + pmem_addr;
      else         pmem_data <= 32'hDEAD_BEEF;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One clock cycle. Called at a negedge; drives inputs, checks the request
   // side and any instruction decode consumes at the coming edge, then checks
   // the post-edge outputs, and returns at the following negedge.
   task automatic step(input logic s, input logic r, input logic [31:0] t);
      logic [31:0] p_addr;
      logic [31:0] p_inst;
      logic        p_valid;
      stall           = s;
      redirect        = r;
      redirect_target = t;
      #1;
      check_eq("pmem_en", 32'(pmem_en), 32'(!s || r));
      if (r)       check_eq("pmem_addr_redir", pmem_addr, t);
      else if (!s) check_eq("pmem_addr_seq", pmem_addr, exp_req);
      if (valid && !s && !r) begin
         check_eq("stream_addr", addr, exp_out);
         check_eq("stream_inst", inst, exp_out + 32'h1000);
         exp_out = exp_out + 1;
         n_consumed++;
      end
      p_addr  = addr;
      p_inst  = inst;
      p_valid = valid;
      if (r) begin
         exp_req = t + 1;
         exp_out = t;
      end else if (!s) begin
         exp_req = exp_req + 1;
      end
      @(posedge clk);
      #1;
      if (r) begin
         check_eq("redir_valid", 32'(valid), 32'd0);
         check_eq("redir_inst", inst, 32'd0);
      end else if (s) begin
         check_eq("hold_addr", addr, p_addr);
         check_eq("hold_inst", inst, p_inst);
         check_eq("hold_valid", 32'(valid), 32'(p_valid));
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      check_eq("rst_addr", addr, 32'd0);
      check_eq("rst_inst", inst, 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_pmem_addr", pmem_addr, RST_PC);

      // Reset release with stall low: first instruction after two edges.
      rst = 1'b0;
      step(1'b0, 1'b0, '0);
      check_eq("start_e1_valid", 32'(valid), 32'd0);
      step(1'b0, 1'b0, '0);
      check_eq("start_e2_valid", 32'(valid), 32'd1);
      check_eq("start_e2_addr", addr, 32'd0);
      check_eq("start_e2_inst", inst, 32'h1000);
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b0, '0);
         check_eq("start_seq_addr", addr, 32'(i));
      end

      // Stall three cycles with addr 4 presented and 5 in flight.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, '0);
         check_eq("stall_hold_addr", addr, 32'd4);
         check_eq("stall_hold_valid", 32'(valid), 32'd1);
      end
      step(1'b0, 1'b0, '0);
      check_eq("stall_resume_5", addr, 32'd5);
      check_eq("stall_resume_5i", inst, 32'h1005);
      step(1'b0, 1'b0, '0);
      check_eq("stall_resume_6", addr, 32'd6);

      // Redirect while streaming.
      step(1'b0, 1'b1, 32'h40);
      check_eq("redir_bubble_valid", 32'(valid), 32'd0);
      step(1'b0, 1'b0, '0);
      check_eq("redir_first", addr, 32'h40);
      check_eq("redir_first_valid", 32'(valid), 32'd1);
      step(1'b0, 1'b0, '0);
      check_eq("redir_second", addr, 32'h41);

      // Redirect together with stall while HELD.
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h40);
      check_eq("held_redir_valid", 32'(valid), 32'd0);
      step(1'b1, 1'b0, '0);
      check_eq("held_redir_still", 32'(valid), 32'd0);
      step(1'b0, 1'b0, '0);
      check_eq("held_redir_addr", addr, 32'h40);
      check_eq("held_redir_inst", inst, 32'h1040);

      // Wrap of the program counter.
      step(1'b0, 1'b1, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, '0);
      check_eq("wrap_last", addr, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, '0);
      check_eq("wrap_zero", addr, 32'h0);
      check_eq("wrap_zero_inst", inst, 32'h1000);

      // Asynchronous reset while stalled in HELD.
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      stall = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_eq("arst_addr", addr, 32'd0);
      check_eq("arst_inst", inst, 32'd0);
      check_eq("arst_valid", 32'(valid), 32'd0);
      check_eq("arst_pmem_addr", pmem_addr, RST_PC);
      @(negedge clk);
      rst     = 1'b0;
      exp_req = RST_PC;
      exp_out = RST_PC;
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      check_eq("arst_restart_addr", addr, RST_PC);
      check_eq("arst_restart_valid", 32'(valid), 32'd1);

      // Random stall/redirect traffic against the stream model.
      n_consumed = 0;
      for (int i = 0; i < 2000; i++) begin
         logic        s;
         logic        r;
         logic [31:0] t;
         s = ($urandom_range(0, 99) < 40);
         r = ($urandom_range(0, 99) < 6);
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else                           t = $urandom;
         step(s, r, t);
      end
      check_eq("liveness", 32'(n_consumed > 300), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, giving the width of addresses and instructions.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first program address fetched after reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; rst is asynchronous and active-high.
REQ-004 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit; when high, decode cannot accept a new instruction.
REQ-006 The block SHALL have port redirect, input, 1 bit, a taken jump (JR/JPC/CALL) resolved downstream.
REQ-007 The block SHALL have port redirect_target, input, DWIDTH bits, the jump destination address.
REQ-008 The block SHALL have port pmem_en, output, 1 bit, the program-memory read enable.
REQ-009 The block SHALL have port pmem_addr, output, DWIDTH bits, the program-memory read address.
REQ-010 The block SHALL have port pmem_data, input, DWIDTH bits, read data valid exactly one cycle after an enabled request.
REQ-011 The block SHALL have port addr, output, DWIDTH bits, the address of the presented instruction; it feeds decode addr.
REQ-012 The block SHALL have port inst, output, DWIDTH bits, the presented instruction; it feeds decode inst.
REQ-013 The block SHALL have port valid, output, 1 bit, which is high when inst/addr carry a real instruction.

Function
REQ-014 The block SHALL keep the internal state pc (next address), req_addr/req_valid (one request in flight) and a one-entry skid buffer (skid_addr, skid_inst, skid_valid).
REQ-015 The FSM SHALL be derived as follows: EMPTY (no request in flight, skid empty), INFLIGHT (req_valid=1) or HELD (skid_valid=1); INFLIGHT and HELD are mutually exclusive.
REQ-016 pmem_en SHALL equal (not stall) or redirect; pmem_addr SHALL equal redirect_target when redirect is high, else pc; both are combinational.
REQ-017 Redirect SHALL have priority over stall: req_addr <= target, req_valid <= 1, pc <= target+1, skid_valid <= 0, valid <= 0, inst <= NOP (all zeros), and the FSM enters INFLIGHT.
REQ-018 On stall without redirect, pc, addr, inst and valid SHALL hold; in INFLIGHT the block SHALL capture pmem_data and req_addr into the skid, clear req_valid and move to HELD; EMPTY and HELD SHALL hold.
REQ-019 On advance (no stall, no redirect), outputs SHALL load from the skid if HELD, from pmem_data/req_addr with valid=1 if INFLIGHT, or take valid=0 and inst=NOP if EMPTY.
REQ-020 On advance, the block SHALL issue req_addr <= pc and req_valid <= 1, increment pc by 1 (wrapping modulo 2^DWIDTH), clear skid_valid and enter INFLIGHT.
REQ-021 Latency SHALL be two rising edges from an issued request to the instruction appearing on inst with valid=1.
REQ-022 Instructions SHALL never be dropped or duplicated across any stall length; only a redirect discards the in-flight or skid instruction.
REQ-023 A redirect while stalled SHALL discard the skid and the held output (valid <= 0).
REQ-024 The block SHALL pass inst through unmodified; opcode inst[31:27] decoding is not performed here.

Reset
REQ-025 While rst is high, pc SHALL equal RESET_PC, req_valid and skid_valid SHALL be 0, addr and inst SHALL be 0, valid SHALL be 0, and the FSM SHALL be EMPTY.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight and skid data immediately.
REQ-027 On the first edge after rst deasserts with stall low, the block SHALL issue a fetch of RESET_PC.

Structure
REQ-028 The opcode constants JR=5'b01101, JPC=5'b01110, CALL=5'b10000, the NOP word and the FSM state encodings SHALL live in the shared processor package.
REQ-029 The skid buffer SHALL be a sub-module named fetch_skid (capture, hold, clear); everything else SHALL be a single module.

Verification
REQ-030 Scenario: reset release with mem[i]=0x1000+i and stall low -> valid rises on edge 2 with addr=0, inst=0x1000, then addr=1, 2, 3 on consecutive cycles.
REQ-031 Scenario: stall for 3 cycles while addr 5 is in flight -> output holds addr 4, pmem_en=0 for 3 cycles, then addr 5, 6 in order with no gap or duplicate.
REQ-032 Scenario: redirect to 0x40 while streaming -> the next cycle has valid=0 and inst=0, then addr=0x40 and 0x41 follow.
REQ-033 Scenario: redirect and stall high together in HELD -> skid discarded, valid=0, and 0x40 is fetched when stall drops.
REQ-034 Scenario: pc=0xFFFFFFFF -> the next request address is 0x00000000.
REQ-035 Scenario: rst pulsed during stall in HELD -> all outputs read 0 asynchronously, and fetch restarts at RESET_PC.
